// File: rtl/apb_pkg.sv
// apb_pkg: shared APB master width defaults, FSM state type and latched command struct
package apb_pkg;
  localparam int APB_ADDR_WIDTH = 32;
  localparam int APB_DATA_WIDTH = 32;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;
  typedef struct packed {
    logic                      write;
    logic [APB_ADDR_WIDTH-1:0] addr;
    logic [APB_DATA_WIDTH-1:0] wdata;
  } apb_cmd_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; req+ptr in, one-hot gnt and valid out, search starts at ptr
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic               valid
);
  logic [2*NUM_REQ-1:0] dbl, back;
  logic [NUM_REQ-1:0]   rot, pick;
  assign dbl   = {req, req} >> ptr;
  assign rot   = dbl[NUM_REQ-1:0];
  assign pick  = rot & (-rot);
  assign back  = {pick, pick} << ptr;
  assign gnt   = back[2*NUM_REQ-1:NUM_REQ];
  assign valid = |req;
endmodule

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin shares one APB master port (PSELx/PENABLE/PWRITE/PADDR/PWDATA out, PRDATA/PREADY/PSLVERR in) among NUM_REQ requesters (req_* in, req_ready/rsp_* out) with optional timeout
module apb_master_arbiter import apb_pkg::*; #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          PCLK,
  input  logic                          PRESETn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic                          PSELx,
  output logic                          PENABLE,
  output logic                          PWRITE,
  output logic [ADDR_WIDTH-1:0]         PADDR,
  output logic [DATA_WIDTH-1:0]         PWDATA,
  input  logic [DATA_WIDTH-1:0]         PRDATA,
  input  logic                          PREADY,
  input  logic                          PSLVERR
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
  apb_state_e            state;
  logic [PW-1:0]         ptr, widx, ptr_next;
  logic [CW-1:0]         cnt;
  logic [NUM_REQ-1:0]    gnt, owner;
  logic                  gvalid, w_write, tout;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_rr (
    .req  (req_valid),
    .ptr  (ptr),
    .gnt  (gnt),
    .valid(gvalid)
  );
  always_comb begin
    widx    = '0;
    w_write = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) begin
        widx    = PW'(i);
        w_write = req_write[i];
        w_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
  end
  assign ptr_next = (widx == PW'(NUM_REQ - 1)) ? '0 : widx + PW'(1);
  assign tout     = (TIMEOUT_CYCLES != 0) && (cnt == CW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      owner     <= '0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      PSELx     <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      if (state == SETUP) begin
        state   <= ACCESS;
        PENABLE <= 1'b1;
      end else if (state == ACCESS && !PREADY) begin
        cnt <= cnt + CW'(1);
        if (tout) begin
          state     <= IDLE;
          PSELx     <= 1'b0;
          PENABLE   <= 1'b0;
          rsp_valid <= owner;
          rsp_err   <= 1'b1;
        end
      end else begin
        if (state == ACCESS) begin
          rsp_valid <= owner;
          rsp_err   <= PSLVERR;
          rsp_rdata <= PWRITE ? '0 : PRDATA;
        end
        PENABLE <= 1'b0;
        PSELx   <= gvalid;
        state   <= gvalid ? SETUP : IDLE;
        if (gvalid) begin
          req_ready <= gnt;
          owner     <= gnt;
          ptr       <= ptr_next;
          cnt       <= '0;
          PWRITE    <= w_write;
          PADDR     <= w_addr;
          PWDATA    <= w_write ? w_wdata : '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: randomized requesters and APB slave, scoreboarded against a round-robin/transaction reference model
module tb_apb_master_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;
  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  logic [N-1:0] req_valid = '0, req_write = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0] req_ready, rsp_valid;
  logic [DW-1:0] rsp_rdata, PWDATA;
  logic rsp_err, PSELx, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PRDATA = '0;
  logic PREADY = 1'b0, PSLVERR = 1'b0;
  apb_master_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );
  always #5 PCLK = ~PCLK;
  typedef struct {logic write; logic [31:0] addr; logic [31:0] wdata;} cmd_t;
  typedef struct {logic [31:0] rdata; logic err; logic hang;} exp_t;
  cmd_t cq[N][$];
  exp_t rq[N][$];
  int gap[N];
  int ptr = 0, nvec = 0, nerr = 0, wmode = -1, waits = 0, wcnt = 0;
  logic hang_cur = 1'b0, prev_psel = 1'b0;
  cmd_t cur;
  function automatic logic [31:0] fdat(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction
  function automatic logic is_hang(logic [31:0] a);
    return a[11:8] == 4'hF;
  endfunction
  function automatic cmd_t mk(logic w, logic [31:0] a, logic [31:0] d);
    cmd_t c;
    c.write = w;
    c.addr  = a;
    c.wdata = d;
    return c;
  endfunction
  function automatic cmd_t rnd();
    return mk(1'($urandom_range(0, 1)), $urandom, $urandom);
  endfunction
  function automatic logic busy();
    for (int i = 0; i < N; i++) if (cq[i].size() != 0 || rq[i].size() != 0) return 1'b1;
    return PSELx;
  endfunction
  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    exp_t e;
    int w;
    logic tout;
    logic [N-1:0] eg;
    @(negedge PCLK);
    tout = 1'b0;
    if (|rsp_valid) begin
      w = 0;
      for (int i = 0; i < N; i++) if (rsp_valid[i]) w = i;
      chk("rsp_onehot", 128'($countones(rsp_valid)), 128'd1);
      if (rq[w].size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL rsp_unexpected: requester %0d got rsp_valid with nothing outstanding", w);
      end else begin
        e = rq[w].pop_front();
        tout = e.hang;
        chk("rsp_rdata", 128'(rsp_rdata), 128'(e.rdata));
        chk("rsp_err", 128'(rsp_err), 128'(e.err));
        chk("access_len", 128'(wcnt), 128'(e.hang ? TO : waits + 1));
        if (e.hang) chk("timeout_bus_idle", 128'({PSELx, PENABLE}), 128'd0);
      end
    end
    eg = '0;
    if (|req_valid && (!prev_psel || (|rsp_valid && !tout)))
      for (int k = 0; k < N; k++)
        if (eg == '0 && req_valid[(ptr + k) % N]) eg[(ptr + k) % N] = 1'b1;
    chk("req_ready", 128'(req_ready), 128'(eg));
    if (eg != '0) begin
      w = 0;
      for (int i = 0; i < N; i++) if (eg[i]) w = i;
      ptr = (w + 1) % N;
      cur = cq[w].pop_front();
      e.hang  = is_hang(cur.addr);
      e.err   = e.hang | cur.addr[2];
      e.rdata = (cur.write || e.hang) ? 32'h0 : fdat(cur.addr);
      rq[w].push_back(e);
      chk("setup_bus", 128'({PSELx, PENABLE, PWRITE, PADDR, PWDATA}),
          128'({2'b10, cur.write, cur.addr, cur.write ? cur.wdata : 32'h0}));
      gap[w] = $urandom_range(0, 2);
    end
    if (PSELx && !PENABLE) begin
      waits    = wmode >= 0 ? wmode : $urandom_range(0, 4);
      wcnt     = 0;
      hang_cur = is_hang(PADDR);
      PREADY   = 1'b0;
    end else if (PSELx && PENABLE) begin
      chk("access_hold", 128'({PWRITE, PADDR, PWDATA}),
          128'({cur.write, cur.addr, cur.write ? cur.wdata : 32'h0}));
      PREADY  = !hang_cur && wcnt >= waits;
      wcnt++;
      PRDATA  = PREADY ? fdat(PADDR) : $urandom;
      PSLVERR = PREADY ? PADDR[2] : 1'($urandom);
    end else PREADY = 1'b0;
    prev_psel = PSELx;
    for (int i = 0; i < N; i++) begin
      if (gap[i] > 0) begin
        gap[i]--;
        req_valid[i] = 1'b0;
      end else if (cq[i].size() != 0) begin
        req_valid[i] = 1'b1;
        req_write[i] = cq[i][0].write;
        req_addr[i*AW +: AW]  = cq[i][0].addr;
        req_wdata[i*DW +: DW] = cq[i][0].wdata;
      end else req_valid[i] = 1'b0;
    end
  endtask
  task automatic drain();
    int t = 0;
    while (busy() && t < 3000) begin
      step();
      t++;
    end
    if (t >= 3000) begin
      nvec++;
      nerr++;
      $display("FAIL drain_timeout: transfers still pending after %0d cycles", t);
    end
    repeat (2) step();
  endtask
  initial begin
    int t;
    for (int i = 0; i < N; i++) gap[i] = 0;
    repeat (3) step();
    chk("reset_outputs", 128'({req_ready, rsp_valid, rsp_rdata, rsp_err, PSELx, PENABLE, PWRITE, PADDR, PWDATA}), 128'd0);
    PRESETn = 1'b1;
    wmode = 0;
    cq[0].push_back(mk(1'b1, 32'h10, 32'hDEADBEEF));
    drain();
    wmode = 3;
    cq[2].push_back(mk(1'b0, 32'h20, 32'h0));
    drain();
    wmode = 1;
    cq[1].push_back(mk(1'b1, 32'h14, 32'h55));
    cq[3].push_back(mk(1'b0, 32'h30, 32'h0));
    drain();
    wmode = -1;
    for (int i = 0; i < N; i++) repeat (2) cq[i].push_back(rnd());
    drain();
    cq[1].push_back(mk(1'b0, 32'hF00, 32'h0));
    drain();
    for (int i = 0; i < N; i++) repeat (8) cq[i].push_back(rnd());
    drain();
    cq[2].push_back(mk(1'b0, 32'hF04, 32'h0));
    t = 0;
    while (!(PSELx && PENABLE) && t < 50) begin
      step();
      t++;
    end
    chk("midreset_reached_access", 128'({PSELx, PENABLE}), 128'd3);
    repeat (2) step();
    PRESETn = 1'b0;
    step();
    chk("midreset_outputs", 128'({req_ready, rsp_valid, rsp_rdata, rsp_err, PSELx, PENABLE, PWRITE, PADDR, PWDATA}), 128'd0);
    for (int i = 0; i < N; i++) rq[i].delete();
    ptr = 0;
    PRESETn = 1'b1;
    cq[3].push_back(mk(1'b1, 32'h40, 32'h1111));
    cq[0].push_back(mk(1'b0, 32'h44, 32'h0));
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
